// File: rtl/checksum_checker.sv
// checksum_checker: turns per-item ones'-complement sums from the checksum calculator into a
// registered good/bypass verdict. Statistics counters exist only with CHSUM_CHECKER_STATS_EN defined.
module checksum_checker #(
    parameter int    MVB_ITEMS      = 4,
    parameter int    MFB_META_WIDTH = 8,
    parameter int    CHSUM_WIDTH    = 16,
    parameter int    CNT_WIDTH      = 32,
    parameter string DEVICE         = "AGILEX"
) (
    input  logic                                CLK,
    input  logic                                RESET_N,

    input  logic [MVB_ITEMS*CHSUM_WIDTH-1:0]    RX_MVB_DATA,
    input  logic [MVB_ITEMS*MFB_META_WIDTH-1:0] RX_MVB_META,
    input  logic [MVB_ITEMS-1:0]                RX_CHSUM_BYPASS,
    input  logic [MVB_ITEMS-1:0]                RX_MVB_VLD,
    input  logic                                RX_MVB_SRC_RDY,
    output logic                                RX_MVB_DST_RDY,

    output logic [MVB_ITEMS-1:0]                TX_CHSUM_OK,
    output logic [MVB_ITEMS-1:0]                TX_CHSUM_BYPASS,
    output logic [MVB_ITEMS*MFB_META_WIDTH-1:0] TX_MVB_META,
    output logic [MVB_ITEMS-1:0]                TX_MVB_VLD,
    output logic                                TX_MVB_SRC_RDY,
    input  logic                                TX_MVB_DST_RDY,

    input  logic                                CNT_CLR,
    output logic [CNT_WIDTH-1:0]                CNT_OK,
    output logic [CNT_WIDTH-1:0]                CNT_BAD,
    output logic [CNT_WIDTH-1:0]                CNT_BYPASS
);

    localparam int INC_W = $clog2(MVB_ITEMS + 1);
    localparam bit unused_device = (DEVICE != "");

    logic [MVB_ITEMS-1:0] item_ok;
    logic [MVB_ITEMS-1:0] item_byp;

    // A correct packet sums to all ones; an all-zero sum is the other zero and still counts as bad.
    for (genvar gi = 0; gi < MVB_ITEMS; gi++) begin : g_item
        assign item_ok[gi]  = RX_MVB_VLD[gi] && !RX_CHSUM_BYPASS[gi]
                              && (RX_MVB_DATA[gi*CHSUM_WIDTH +: CHSUM_WIDTH] == {CHSUM_WIDTH{1'b1}});
        assign item_byp[gi] = RX_MVB_VLD[gi] && RX_CHSUM_BYPASS[gi];
    end

    logic                                out_vld_q, out_vld_d;
    logic [MVB_ITEMS-1:0]                vld_q, vld_d;
    logic [MVB_ITEMS-1:0]                ok_q, ok_d;
    logic [MVB_ITEMS-1:0]                byp_q, byp_d;
    logic [MVB_ITEMS*MFB_META_WIDTH-1:0] meta_q, meta_d;
    logic                                rx_dst_rdy;
    logic                                rx_xfer;
    logic                                rx_load;

    assign rx_dst_rdy = !out_vld_q || TX_MVB_DST_RDY;
    assign rx_xfer    = RX_MVB_SRC_RDY && rx_dst_rdy;
    assign rx_load    = rx_xfer && (|RX_MVB_VLD);

    // Words with no valid item are swallowed so they never occupy the output slot.
    always_comb begin
        out_vld_d = out_vld_q;
        vld_d     = vld_q;
        ok_d      = ok_q;
        byp_d     = byp_q;
        meta_d    = meta_q;
        if (rx_load) begin
            out_vld_d = 1'b1;
            vld_d     = RX_MVB_VLD;
            ok_d      = item_ok;
            byp_d     = item_byp;
            meta_d    = RX_MVB_META;
        end else if (TX_MVB_DST_RDY) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_vld_q <= 1'b0;
            vld_q     <= '0;
            ok_q      <= '0;
            byp_q     <= '0;
            meta_q    <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            vld_q     <= vld_d;
            ok_q      <= ok_d;
            byp_q     <= byp_d;
            meta_q    <= meta_d;
        end
    end

    assign RX_MVB_DST_RDY  = rx_dst_rdy;
    assign TX_MVB_SRC_RDY  = out_vld_q;
    assign TX_MVB_VLD      = vld_q & {MVB_ITEMS{out_vld_q}};
    assign TX_CHSUM_OK     = ok_q;
    assign TX_CHSUM_BYPASS = byp_q;
    assign TX_MVB_META     = meta_q;

`ifdef CHSUM_CHECKER_STATS_EN
    logic [MVB_ITEMS-1:0]      item_bad;
    logic [2:0][MVB_ITEMS-1:0] cnt_src;

    assign item_bad = RX_MVB_VLD & ~item_ok & ~RX_CHSUM_BYPASS;
    assign cnt_src  = {item_byp, item_bad, item_ok};

    // One saturating counter per class; a clear coinciding with a transfer restarts from that word.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [INC_W-1:0]     inc;
        logic [CNT_WIDTH:0]   sum;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

        always_comb begin
            inc = '0;
            for (int i = 0; i < MVB_ITEMS; i++) begin
                inc = inc + INC_W'(cnt_src[gi][i]);
            end
            sum   = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc);
            cnt_d = cnt_q;
            if (CNT_CLR) begin
                cnt_d = rx_xfer ? CNT_WIDTH'(inc) : '0;
            end else if (rx_xfer) begin
                cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
            end
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign CNT_OK     = g_cnt[0].cnt_q;
    assign CNT_BAD    = g_cnt[1].cnt_q;
    assign CNT_BYPASS = g_cnt[2].cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = CNT_CLR;
    assign CNT_OK         = '0;
    assign CNT_BAD        = '0;
    assign CNT_BYPASS     = '0;
`endif

endmodule

// File: tb/tb_checksum_checker.sv
// Bench for checksum_checker: directed and random words scored against a queue-based model;
// a second instance with 4-bit counters exercises saturation on the same stimulus.
module tb_checksum_checker;

    localparam int N  = 4;
    localparam int MW = 8;

    typedef struct {
        logic [N-1:0]    vld;
        logic [N-1:0]    ok;
        logic [N-1:0]    byp;
        logic [N*MW-1:0] meta;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*16-1:0] rx_data;
    logic [N*MW-1:0] rx_meta;
    logic [N-1:0]    rx_byp, rx_vld;
    logic            rx_src, tx_dst, cnt_clr;

    logic            rx_dst, tx_src, s_rx_dst, s_tx_src;
    logic [N-1:0]    tx_ok, tx_byp, tx_vld, s_tx_ok, s_tx_byp, s_tx_vld;
    logic [N*MW-1:0] tx_meta, s_tx_meta;
    logic [31:0]     cnt_ok, cnt_bad, cnt_byp;
    logic [3:0]      s_cnt_ok, s_cnt_bad, s_cnt_byp;

    checksum_checker #(.MVB_ITEMS(N), .MFB_META_WIDTH(MW), .CNT_WIDTH(32)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .RX_MVB_DATA(rx_data), .RX_MVB_META(rx_meta), .RX_CHSUM_BYPASS(rx_byp),
        .RX_MVB_VLD(rx_vld), .RX_MVB_SRC_RDY(rx_src), .RX_MVB_DST_RDY(rx_dst),
        .TX_CHSUM_OK(tx_ok), .TX_CHSUM_BYPASS(tx_byp), .TX_MVB_META(tx_meta),
        .TX_MVB_VLD(tx_vld), .TX_MVB_SRC_RDY(tx_src), .TX_MVB_DST_RDY(tx_dst),
        .CNT_CLR(cnt_clr), .CNT_OK(cnt_ok), .CNT_BAD(cnt_bad), .CNT_BYPASS(cnt_byp)
    );

    checksum_checker #(.MVB_ITEMS(N), .MFB_META_WIDTH(MW), .CNT_WIDTH(4)) dut_sat (
        .CLK(clk), .RESET_N(rst_n),
        .RX_MVB_DATA(rx_data), .RX_MVB_META(rx_meta), .RX_CHSUM_BYPASS(rx_byp),
        .RX_MVB_VLD(rx_vld), .RX_MVB_SRC_RDY(rx_src), .RX_MVB_DST_RDY(s_rx_dst),
        .TX_CHSUM_OK(s_tx_ok), .TX_CHSUM_BYPASS(s_tx_byp), .TX_MVB_META(s_tx_meta),
        .TX_MVB_VLD(s_tx_vld), .TX_MVB_SRC_RDY(s_tx_src), .TX_MVB_DST_RDY(tx_dst),
        .CNT_CLR(cnt_clr), .CNT_OK(s_cnt_ok), .CNT_BAD(s_cnt_bad), .CNT_BYPASS(s_cnt_byp)
    );

    word_t  q[$];
    longint tot_ok, tot_bad, tot_byp;
    int     checks = 0;
    int     errors = 0;

    // Counters track unbounded totals since the last clear, clipped to the counter width.
    function automatic logic [31:0] exp_cnt(longint tot, int w);
`ifdef CHSUM_CHECKER_STATS_EN
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (tot > mx) ? mx[31:0] : tot[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [N*MW-1:0] mask_meta(logic [N*MW-1:0] m, logic [N-1:0] v);
        logic [N*MW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (v[i]) r[i*MW +: MW] = m[i*MW +: MW];
        return r;
    endfunction

    task automatic rand_inputs(input int src_pct, input bit force_vld);
        rx_src = ($urandom_range(0, 99) < src_pct);
        rx_vld = 4'($urandom_range(0, 15));
        if (force_vld && rx_vld == 0) rx_vld = 4'b0001;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    rx_data[i*16 +: 16] = 16'hFFFF;
                2:       rx_data[i*16 +: 16] = 16'h0000;
                default: rx_data[i*16 +: 16] = 16'($urandom);
            endcase
        end
        rx_byp  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        rx_meta = $urandom;
    endtask

    // Model update for the coming rising edge, then advance to the next falling edge.
    task automatic tick();
        word_t w;
        logic  xfer;
        int    i_ok, i_bad, i_byp;
        xfer = rx_src && (q.size() == 0 || tx_dst);
        i_ok = 0; i_bad = 0; i_byp = 0;
        w.vld = rx_vld; w.ok = '0; w.byp = rx_byp & rx_vld;
        w.meta = mask_meta(rx_meta, rx_vld);
        for (int i = 0; i < N; i++) begin
            if (rx_vld[i]) begin
                if (rx_byp[i]) i_byp++;
                else if (rx_data[i*16 +: 16] == 16'hFFFF) begin i_ok++; w.ok[i] = 1'b1; end
                else i_bad++;
            end
        end
        if (q.size() != 0 && tx_dst) q.delete(0);
        if (xfer && rx_vld != 0) begin
            q.push_back(w);
            $display("xfer vld=%b ok=%b byp=%b meta=%h", w.vld, w.ok, w.byp, w.meta);
        end
        if (cnt_clr) begin
            tot_ok  = xfer ? i_ok  : 0;
            tot_bad = xfer ? i_bad : 0;
            tot_byp = xfer ? i_byp : 0;
        end else if (xfer) begin
            tot_ok  += i_ok;
            tot_bad += i_bad;
            tot_byp += i_byp;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rx_src = 1'b0; rx_vld = '0; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle(); tx_dst = 1'b1; rx_data = '0; rx_meta = '0; rx_byp = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_src, tx_vld, tx_ok, tx_byp, tx_meta} !== '0)
            $display("FAIL reset_out: got %h required 0", {tx_src, tx_vld, tx_ok, tx_byp, tx_meta});
        checks++;
        if ({cnt_ok, cnt_bad, cnt_byp, s_cnt_ok, s_cnt_bad, s_cnt_byp} !== '0)
            $display("FAIL reset_cnt: got %h required 0", {cnt_ok, cnt_bad, cnt_byp});
        checks++;
        if (rx_dst !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b required 1", rx_dst); end
        if ({tx_src, tx_vld, tx_ok, tx_byp, tx_meta} !== '0) errors++;
        if ({cnt_ok, cnt_bad, cnt_byp, s_cnt_ok, s_cnt_bad, s_cnt_byp} !== '0) errors++;
        rst_n = 1'b1;
        q.delete(); tot_ok = 0; tot_bad = 0; tot_byp = 0;
    endtask

    task automatic test_good_packet();
        rx_src = 1'b1; rx_vld = 4'b0001; rx_byp = '0;
        rx_data = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}; rx_meta = 32'h0000_005A;
        tick();
        idle();
        checks++;
        if (tx_src !== 1'b1 || tx_vld !== 4'b0001 || tx_ok[0] !== 1'b1 || tx_meta[7:0] !== 8'h5A) begin
            errors++;
            $display("FAIL good_packet: got src=%b vld=%b ok=%b meta=%h required 1 0001 xxx1 5a",
                     tx_src, tx_vld, tx_ok, tx_meta[7:0]);
        end
        checks++;
        if (cnt_ok !== exp_cnt(64'd1, 32)) begin
            errors++; $display("FAIL good_cnt_ok: got %0d required %0d", cnt_ok, exp_cnt(64'd1, 32));
        end
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    endtask

    task automatic test_mixed();
        rx_src = 1'b1; rx_vld = 4'b1111; rx_byp = 4'b1000; rx_meta = 32'hA1B2_C3D4;
        rx_data = {16'hFFFF, 16'h1234, 16'h0000, 16'hFFFF};
        tick();
        idle();
        checks++;
        if (tx_src !== 1'b1 || tx_ok !== 4'b0001 || tx_byp !== 4'b1000 || tx_meta !== 32'hA1B2_C3D4) begin
            errors++;
            $display("FAIL mixed_out: got ok=%b byp=%b meta=%h required 0001 1000 a1b2c3d4",
                     tx_ok, tx_byp, tx_meta);
        end
        checks++;
        if ({cnt_ok, cnt_bad, cnt_byp} !== {exp_cnt(64'd1, 32), exp_cnt(64'd2, 32), exp_cnt(64'd1, 32)}) begin
            errors++;
            $display("FAIL mixed_cnt: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_ok, cnt_bad, cnt_byp,
                     exp_cnt(64'd1, 32), exp_cnt(64'd2, 32), exp_cnt(64'd1, 32));
        end
    endtask

    task automatic test_empty();
        tick();
        for (int k = 0; k < 3; k++) begin
            rand_inputs(100, 1'b0); rx_src = 1'b1; rx_vld = '0;
            tick();
            checks++;
            if (tx_src !== 1'b0) begin errors++; $display("FAIL empty_src: got %b required 0", tx_src); end
            checks++;
            if ({cnt_ok, cnt_bad, cnt_byp} !== {exp_cnt(tot_ok, 32), exp_cnt(tot_bad, 32), exp_cnt(tot_byp, 32)}) begin
                errors++;
                $display("FAIL empty_cnt: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_ok, cnt_bad, cnt_byp,
                         exp_cnt(tot_ok, 32), exp_cnt(tot_bad, 32), exp_cnt(tot_byp, 32));
            end
        end
        idle();
    endtask

    task automatic test_backpressure();
        int sent, seen, cyc;
        logic xfer;
        sent = 0; seen = 0; cyc = 0;
        rand_inputs(100, 1'b1); rx_src = 1'b1;
        while ((sent < 8 || q.size() != 0) && cyc < 200) begin
            tx_dst = (cyc >= 5);
            #1;
            xfer = rx_src && (q.size() == 0 || tx_dst);
            if (tx_src === 1'b1 && tx_dst) seen++;
            checks++;
            if (rx_dst !== (q.size() == 0 || tx_dst) || (cyc >= 1 && cyc < 5 && rx_dst !== 1'b0)) begin
                errors++; $display("FAIL bp_rdy cyc %0d: got %b required %b", cyc, rx_dst, q.size() == 0 || tx_dst);
            end
            tick();
            if (xfer) begin
                sent++;
                if (sent < 8) begin rand_inputs(100, 1'b1); rx_src = 1'b1; end
                else idle();
            end
            cyc++;
            checks++;
            if (q.size() != 0) begin
                if (tx_src !== 1'b1 || tx_vld !== q[0].vld || (tx_ok & tx_vld) !== q[0].ok ||
                    (tx_byp & tx_vld) !== q[0].byp || mask_meta(tx_meta, tx_vld) !== q[0].meta) begin
                    errors++;
                    $display("FAIL bp_word cyc %0d: got vld=%b ok=%b meta=%h required %b %b %h", cyc,
                             tx_vld, tx_ok, tx_meta, q[0].vld, q[0].ok, q[0].meta);
                end
            end else if (tx_src !== 1'b0) begin
                errors++; $display("FAIL bp_idle cyc %0d: got src=%b required 0", cyc, tx_src);
            end
        end
        checks++;
        if (seen != 8 || sent != 8) begin
            errors++; $display("FAIL bp_count: got out=%0d in=%0d required 8 8", seen, sent);
        end
        idle(); tx_dst = 1'b1; tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            rand_inputs(75, 1'b0);
            tx_dst  = ($urandom_range(0, 9) < 7);
            cnt_clr = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (rx_dst !== (q.size() == 0 || tx_dst)) begin
                errors++; $display("FAIL rnd_rdy %0d: got %b required %b", k, rx_dst, q.size() == 0 || tx_dst);
            end
            tick();
            checks++;
            if (tx_src !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_src %0d: got %b required %b", k, tx_src, q.size() != 0);
            end else if (q.size() != 0) begin
                if (tx_vld !== q[0].vld || (tx_ok & tx_vld) !== q[0].ok || (tx_byp & tx_vld) !== q[0].byp ||
                    mask_meta(tx_meta, tx_vld) !== q[0].meta) begin
                    errors++;
                    $display("FAIL rnd_word %0d: got vld=%b ok=%b byp=%b meta=%h required %b %b %b %h", k,
                             tx_vld, tx_ok, tx_byp, tx_meta, q[0].vld, q[0].ok, q[0].byp, q[0].meta);
                end
            end
            checks++;
            if ({cnt_ok, cnt_bad, cnt_byp} !== {exp_cnt(tot_ok, 32), exp_cnt(tot_bad, 32), exp_cnt(tot_byp, 32)} ||
                {28'd0, s_cnt_ok} !== exp_cnt(tot_ok, 4) || {28'd0, s_cnt_bad} !== exp_cnt(tot_bad, 4) ||
                {28'd0, s_cnt_byp} !== exp_cnt(tot_byp, 4)) begin
                errors++;
                $display("FAIL rnd_cnt %0d: got %0d/%0d/%0d sat %0d/%0d/%0d required totals %0d/%0d/%0d", k,
                         cnt_ok, cnt_bad, cnt_byp, s_cnt_ok, s_cnt_bad, s_cnt_byp, tot_ok, tot_bad, tot_byp);
            end
        end
        idle(); tx_dst = 1'b1; tick();
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rx_src = 1'b1; rx_vld = 4'b1111; rx_byp = '0; rx_data = '1; rx_meta = $urandom;
            tick();
        end
        idle(); tick();
        checks++;
        if ({28'd0, s_cnt_ok} !== exp_cnt(64'd20, 4) || cnt_ok !== exp_cnt(64'd20, 32)) begin
            errors++; $display("FAIL sat_cnt: got %0d/%0d required %0d/%0d", s_cnt_ok, cnt_ok,
                               exp_cnt(64'd20, 4), exp_cnt(64'd20, 32));
        end
        rx_src = 1'b1; rx_vld = 4'b0011; rx_byp = '0; rx_data = '1; cnt_clr = 1'b1;
        tick();
        idle();
        checks++;
        if ({28'd0, s_cnt_ok} !== exp_cnt(64'd2, 4) || cnt_ok !== exp_cnt(64'd2, 32) || s_cnt_bad !== 4'd0) begin
            errors++; $display("FAIL clr_xfer: got %0d/%0d required %0d", s_cnt_ok, cnt_ok, exp_cnt(64'd2, 32));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        tx_dst = 1'b0;
        rand_inputs(100, 1'b1); rx_src = 1'b1;
        tick();
        rand_inputs(100, 1'b1); rx_src = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_src !== 1'b0 || tx_vld !== '0 || rx_dst !== 1'b1) begin
            errors++; $display("FAIL rst_mid_out: got src=%b vld=%b rdy=%b required 0 0000 1", tx_src, tx_vld, rx_dst);
        end
        checks++;
        if ({cnt_ok, cnt_bad, cnt_byp, s_cnt_ok, s_cnt_bad, s_cnt_byp} !== '0) begin
            errors++; $display("FAIL rst_mid_cnt: got %0d/%0d/%0d required 0", cnt_ok, cnt_bad, cnt_byp);
        end
        @(negedge clk);
        rst_n = 1'b1; tx_dst = 1'b1;
        q.delete(); tot_ok = 0; tot_bad = 0; tot_byp = 0;
        rx_src = 1'b1; rx_vld = 4'b0100; rx_byp = '0; rx_data = '1; rx_meta = 32'h0077_0000;
        tick();
        idle();
        checks++;
        if (tx_src !== 1'b1 || tx_vld !== 4'b0100 || tx_ok[2] !== 1'b1 || tx_meta[23:16] !== 8'h77 ||
            cnt_ok !== exp_cnt(64'd1, 32)) begin
            errors++; $display("FAIL rst_after: got src=%b vld=%b ok=%b cnt=%0d required 1 0100 x1xx %0d",
                               tx_src, tx_vld, tx_ok, cnt_ok, exp_cnt(64'd1, 32));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_mixed();
        test_empty();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
